// File: rtl/speed_level_controller_pkg.sv
// rtl/speed_level_controller_pkg.sv - shared state encoding and default parameters
//   Package speed_ctrl_pkg: FSM state type (3-bit) and default parameter values
//   used by the controller top, its tick counter and its bus interface.
package speed_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CALC   = 3'd1,
        LOAD   = 3'd2,
        SETTLE = 3'd3,
        RUN    = 3'd4
    } speedState_t;

    localparam int DEF_DATAWIDTH  = 28;
    localparam int DEF_LEVELWIDTH = 3;
    localparam int DEF_NUMLEVELS  = 8;
    localparam int DEF_LIMITBASE  = 50000000;
    localparam int DEF_LIMITSTEP  = 5000000;
    localparam int DEF_LIMITMIN   = 5000000;

endpackage

// File: rtl/speed_level_controller_if.sv
// rtl/speed_level_controller_if.sv - control and comparator signals of the speed level controller
//   master modport: controller side (takes start/stop/pause/levelUp/cmp,
//                   drives limit/load/data/tick/level/running)
//   slave modport : game logic plus comparator side (the mirror image)
interface speed_level_controller_if
    import speed_ctrl_pkg::*;
#(
    parameter int DATAWIDTH  = DEF_DATAWIDTH,
    parameter int LEVELWIDTH = DEF_LEVELWIDTH
);

    logic                  SPEEDCTRL_start_InLow;
    logic                  SPEEDCTRL_stop_InLow;
    logic                  SPEEDCTRL_pause_InLow;
    logic                  SPEEDCTRL_levelUp_InLow;
    logic                  SPEEDCTRL_cmp_InLow;
    logic [DATAWIDTH-1:0]  SPEEDCTRL_limit_OutBUS;
    logic                  SPEEDCTRL_load_OutLow;
    logic [DATAWIDTH-1:0]  SPEEDCTRL_data_OutBUS;
    logic                  SPEEDCTRL_tick_Out;
    logic [LEVELWIDTH-1:0] SPEEDCTRL_level_OutBUS;
    logic                  SPEEDCTRL_running_Out;

    modport master (
        input  SPEEDCTRL_start_InLow, SPEEDCTRL_stop_InLow, SPEEDCTRL_pause_InLow,
               SPEEDCTRL_levelUp_InLow, SPEEDCTRL_cmp_InLow,
        output SPEEDCTRL_limit_OutBUS, SPEEDCTRL_load_OutLow, SPEEDCTRL_data_OutBUS,
               SPEEDCTRL_tick_Out, SPEEDCTRL_level_OutBUS, SPEEDCTRL_running_Out
    );

    modport slave (
        output SPEEDCTRL_start_InLow, SPEEDCTRL_stop_InLow, SPEEDCTRL_pause_InLow,
               SPEEDCTRL_levelUp_InLow, SPEEDCTRL_cmp_InLow,
        input  SPEEDCTRL_limit_OutBUS, SPEEDCTRL_load_OutLow, SPEEDCTRL_data_OutBUS,
               SPEEDCTRL_tick_Out, SPEEDCTRL_level_OutBUS, SPEEDCTRL_running_Out
    );

endinterface

// File: rtl/speed_level_controller_tick.sv
// rtl/speed_level_controller_tick.sv - data counter watched by the comparator, with tick generation
//   clk, resetInLow : clock and synchronous active-low reset
//   clear           : force count to 0 and tick low (any state other than RUN, or stop)
//   enable          : count/tick only when high (pause input is high)
//   cmp             : active-high match (counter has reached the loaded limit)
//   count           : counter value presented to the comparator
//   tick            : one-cycle pulse issued when a match wraps the counter
module speed_tick_counter
    import speed_ctrl_pkg::*;
#(
    parameter int DATAWIDTH = DEF_DATAWIDTH
) (
    input  logic                 clk,
    input  logic                 resetInLow,
    input  logic                 clear,
    input  logic                 enable,
    input  logic                 cmp,
    output logic [DATAWIDTH-1:0] count,
    output logic                 tick
);

    localparam logic [DATAWIDTH-1:0] COUNT_ONE = DATAWIDTH'(1);

    always_ff @(posedge clk) begin
        if (!resetInLow || clear) begin
            count <= '0;
            tick  <= 1'b0;
        end else if (!enable) begin
            // Paused: the match is ignored and the count is frozen.
            tick <= 1'b0;
        end else if (cmp) begin
            count <= '0;
            tick  <= 1'b1;
        end else begin
            tick <= 1'b0;
            // A comparator that never matches must not let the count wrap
            // back to a value below the limit; park at all-ones instead.
            if (count != '1) begin
                count <= count + COUNT_ONE;
            end
        end
    end

endmodule

// File: rtl/speed_level_controller.sv
// rtl/speed_level_controller.sv - speed level FSM, limit arithmetic and comparator load sequencing
//   SPEEDCTRL_CLOCK_50    : system clock, rising edge
//   SPEEDCTRL_RESET_InLow : synchronous active-low reset
//   bus (master)          : start/stop/pause/levelUp/cmp inputs;
//                           limit/load/data/tick/level/running registered outputs
module speed_level_controller
    import speed_ctrl_pkg::*;
#(
    parameter int SPEEDCTRL_DATAWIDTH  = DEF_DATAWIDTH,
    parameter int SPEEDCTRL_LEVELWIDTH = DEF_LEVELWIDTH,
    parameter int SPEEDCTRL_NUMLEVELS  = DEF_NUMLEVELS,
    parameter int SPEEDCTRL_LIMITBASE  = DEF_LIMITBASE,
    parameter int SPEEDCTRL_LIMITSTEP  = DEF_LIMITSTEP,
    parameter int SPEEDCTRL_LIMITMIN   = DEF_LIMITMIN
) (
    input  logic                     SPEEDCTRL_CLOCK_50,
    input  logic                     SPEEDCTRL_RESET_InLow,
    speed_level_controller_if.master bus
);

    localparam int DW   = SPEEDCTRL_DATAWIDTH;
    localparam int LW   = SPEEDCTRL_LEVELWIDTH;
    localparam int WIDE = DW + LW;

    typedef logic [WIDE-1:0] wide_t;

    localparam wide_t          BASE_W      = wide_t'(SPEEDCTRL_LIMITBASE);
    localparam wide_t          STEP_W      = wide_t'(SPEEDCTRL_LIMITSTEP);
    localparam wide_t          MIN_W       = wide_t'(SPEEDCTRL_LIMITMIN);
    localparam logic [DW-1:0]  LIMIT_RESET = DW'(SPEEDCTRL_LIMITBASE);
    localparam logic [DW-1:0]  LIMIT_FLOOR = DW'(SPEEDCTRL_LIMITMIN);
    localparam logic [LW-1:0]  LEVEL_MAX   = LW'(SPEEDCTRL_NUMLEVELS - 1);
    localparam logic [LW-1:0]  LEVEL_ONE   = LW'(1);

    // Widened so the product cannot wrap; an oversized product or a result
    // under the floor both clamp to the floor.
    function automatic logic [DW-1:0] limitFor(input logic [LW-1:0] lvl);
        wide_t product;
        wide_t diff;
        product = wide_t'(lvl) * STEP_W;
        diff    = BASE_W - product;
        if (product > BASE_W || diff < MIN_W) begin
            return LIMIT_FLOOR;
        end
        return DW'(diff);
    endfunction

    speedState_t     state;
    logic [LW-1:0]   level;
    logic [DW-1:0]   limit;
    logic            load;
    logic            running;

    logic            cntClear;
    logic [DW-1:0]   cntValue;
    logic            cntTick;

    // The counter only runs in RUN; a stop clears it on the same edge the
    // FSM drops back to IDLE.
    assign cntClear = (state != RUN) || !bus.SPEEDCTRL_stop_InLow;

    speed_tick_counter #(
        .DATAWIDTH (DW)
    ) u_tick (
        .clk        (SPEEDCTRL_CLOCK_50),
        .resetInLow (SPEEDCTRL_RESET_InLow),
        .clear      (cntClear),
        .enable     (bus.SPEEDCTRL_pause_InLow),
        .cmp        (!bus.SPEEDCTRL_cmp_InLow),
        .count      (cntValue),
        .tick       (cntTick)
    );

    // The limit register is written on the edge that enters CALC, so it is
    // already stable for the whole CALC cycle before load falls on entry
    // to LOAD; the comparator never sees limit and strobe change together.
    always_ff @(posedge SPEEDCTRL_CLOCK_50) begin
        if (!SPEEDCTRL_RESET_InLow) begin
            state   <= IDLE;
            level   <= '0;
            limit   <= LIMIT_RESET;
            load    <= 1'b1;
            running <= 1'b0;
        end else if (state != IDLE && !bus.SPEEDCTRL_stop_InLow) begin
            state   <= IDLE;
            load    <= 1'b1;
            running <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (!bus.SPEEDCTRL_start_InLow) begin
                        state <= CALC;
                        limit <= limitFor(level);
                    end
                end
                CALC: begin
                    state <= LOAD;
                    load  <= 1'b0;
                end
                LOAD: begin
                    state <= SETTLE;
                    load  <= 1'b1;
                end
                SETTLE: begin
                    state   <= RUN;
                    running <= 1'b1;
                end
                RUN: begin
                    if (!bus.SPEEDCTRL_levelUp_InLow && level < LEVEL_MAX) begin
                        state   <= CALC;
                        level   <= level + LEVEL_ONE;
                        limit   <= limitFor(level + LEVEL_ONE);
                        running <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    load    <= 1'b1;
                    running <= 1'b0;
                end
            endcase
        end
    end

    assign bus.SPEEDCTRL_limit_OutBUS = limit;
    assign bus.SPEEDCTRL_load_OutLow  = load;
    assign bus.SPEEDCTRL_data_OutBUS  = cntValue;
    assign bus.SPEEDCTRL_tick_Out     = cntTick;
    assign bus.SPEEDCTRL_level_OutBUS = level;
    assign bus.SPEEDCTRL_running_Out  = running;

endmodule

// File: tb/tb_speed_level_controller.sv
// tb/tb_speed_level_controller.sv - self-checking bench for speed_level_controller
module tb_speed_level_controller;

    localparam int DW   = 8;
    localparam int LW   = 3;
    localparam int NUM  = 4;
    localparam int BASE = 10;
    localparam int STEP = 3;
    localparam int MINL = 2;

    logic clk = 1'b0;
    logic rstn;
    logic forceCmpHigh = 1'b0;
    logic [DW-1:0] cmpLimit = '1;

    int compared   = 0;
    int mismatched = 0;
    int mLevel     = 0;

    speed_level_controller_if #(.DATAWIDTH(DW), .LEVELWIDTH(LW)) bus ();

    speed_level_controller #(
        .SPEEDCTRL_DATAWIDTH  (DW),
        .SPEEDCTRL_LEVELWIDTH (LW),
        .SPEEDCTRL_NUMLEVELS  (NUM),
        .SPEEDCTRL_LIMITBASE  (BASE),
        .SPEEDCTRL_LIMITSTEP  (STEP),
        .SPEEDCTRL_LIMITMIN   (MINL)
    ) dut (
        .SPEEDCTRL_CLOCK_50    (clk),
        .SPEEDCTRL_RESET_InLow (rstn),
        .bus                   (bus)
    );

    always #5 clk = ~clk;

    // Behavioural comparator: captures limit on the falling edge of load,
    // output low while data >= captured limit.
    always @(negedge bus.SPEEDCTRL_load_OutLow) cmpLimit = bus.SPEEDCTRL_limit_OutBUS;
    assign bus.SPEEDCTRL_cmp_InLow = forceCmpHigh ? 1'b1 : !(bus.SPEEDCTRL_data_OutBUS >= cmpLimit);

    logic [DW-1:0] dLimit, dData;
    logic [LW-1:0] dLevel;
    logic          dLoad, dTick, dRun;
    assign dLimit = bus.SPEEDCTRL_limit_OutBUS;
    assign dData  = bus.SPEEDCTRL_data_OutBUS;
    assign dLevel = bus.SPEEDCTRL_level_OutBUS;
    assign dLoad  = bus.SPEEDCTRL_load_OutLow;
    assign dTick  = bus.SPEEDCTRL_tick_Out;
    assign dRun   = bus.SPEEDCTRL_running_Out;

    // Reference: limit per level from plain integer arithmetic with floor clamp.
    function automatic int modelLimit(input int lvl);
        int v;
        v = BASE - lvl * STEP;
        return (v < MINL) ? MINL : v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulseStart();
        bus.SPEEDCTRL_start_InLow = 1'b0; step(); bus.SPEEDCTRL_start_InLow = 1'b1;
    endtask

    task automatic pulseLevelUp();
        bus.SPEEDCTRL_levelUp_InLow = 1'b0; step(); bus.SPEEDCTRL_levelUp_InLow = 1'b1;
    endtask

    task automatic pulseStop();
        bus.SPEEDCTRL_stop_InLow = 1'b0; step(); bus.SPEEDCTRL_stop_InLow = 1'b1;
    endtask

    // Cycles until tick is observed high; -1 if the bound expires.
    task automatic waitTick(output int n);
        n = -1;
        for (int i = 1; i <= 80; i++) begin
            step();
            if (dTick === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0; step(); step(); rstn = 1'b1;
        compared++;
        if (dLoad !== 1'b1 || dLevel !== 0 || dLimit !== BASE[DW-1:0] ||
            dData !== 0 || dTick !== 1'b0 || dRun !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_state load=%0b level=%0d limit=%0d data=%0d tick=%0b run=%0b want 1/0/%0d/0/0/0",
                     dLoad, dLevel, dLimit, dData, dTick, dRun, BASE);
        end
        mLevel = 0;
    endtask

    task automatic test_start();
        int n;
        repeat ($urandom_range(0, 5)) step();
        pulseStart();
        compared++;
        if (dLoad !== 1'b1 || dLimit !== modelLimit(0) || dRun !== 1'b0) begin
            mismatched++;
            $display("FAIL start_calc load=%0b limit=%0d run=%0b want 1/%0d/0", dLoad, dLimit, dRun, modelLimit(0));
        end
        step();
        compared++;
        if (dLoad !== 1'b0 || dLimit !== modelLimit(0)) begin
            mismatched++;
            $display("FAIL start_load load=%0b limit=%0d want 0/%0d", dLoad, dLimit, modelLimit(0));
        end
        step();
        compared++;
        if (dLoad !== 1'b1 || dRun !== 1'b0) begin
            mismatched++;
            $display("FAIL start_settle load=%0b run=%0b want 1/0", dLoad, dRun);
        end
        step();
        compared++;
        if (dRun !== 1'b1 || dData !== 0) begin
            mismatched++;
            $display("FAIL start_run run=%0b data=%0d want 1/0", dRun, dData);
        end
        waitTick(n);
        compared++;
        if (n !== modelLimit(0) + 1) begin
            mismatched++;
            $display("FAIL start_first_tick got %0d cycles want %0d", n, modelLimit(0) + 1);
        end
        repeat ($urandom_range(2, 4)) begin
            waitTick(n);
            compared++;
            if (n !== modelLimit(0) + 1) begin
                mismatched++;
                $display("FAIL start_period got %0d want %0d", n, modelLimit(0) + 1);
            end
        end
    endtask

    task automatic test_level_up();
        int n;
        for (int k = 1; k < NUM; k++) begin
            repeat ($urandom_range(0, modelLimit(mLevel))) step();
            pulseLevelUp();
            mLevel++;
            compared++;
            if (dLevel !== mLevel || dLimit !== modelLimit(mLevel) || dLoad !== 1'b1 || dRun !== 1'b0) begin
                mismatched++;
                $display("FAIL lvl_calc level=%0d limit=%0d load=%0b run=%0b want %0d/%0d/1/0",
                         dLevel, dLimit, dLoad, dRun, mLevel, modelLimit(mLevel));
            end
            step();
            compared++;
            if (dLoad !== 1'b0 || dLimit !== modelLimit(mLevel)) begin
                mismatched++;
                $display("FAIL lvl_load load=%0b limit=%0d want 0/%0d", dLoad, dLimit, modelLimit(mLevel));
            end
            step(); step();
            compared++;
            if (dLoad !== 1'b1 || dRun !== 1'b1 || dData !== 0) begin
                mismatched++;
                $display("FAIL lvl_run load=%0b run=%0b data=%0d want 1/1/0", dLoad, dRun, dData);
            end
            repeat (2) begin
                waitTick(n);
                compared++;
                if (n !== modelLimit(mLevel) + 1) begin
                    mismatched++;
                    $display("FAIL lvl_period level=%0d got %0d want %0d", mLevel, n, modelLimit(mLevel) + 1);
                end
            end
        end
    endtask

    task automatic test_max_level();
        int n;
        pulseLevelUp();
        for (int i = 0; i < 6; i++) begin
            compared++;
            if (dLoad !== 1'b1 || dRun !== 1'b1 || dLevel !== NUM - 1) begin
                mismatched++;
                $display("FAIL max_ignored load=%0b run=%0b level=%0d want 1/1/%0d", dLoad, dRun, dLevel, NUM - 1);
            end
            step();
        end
        waitTick(n);
        repeat (2) begin
            waitTick(n);
            compared++;
            if (n !== modelLimit(NUM - 1) + 1) begin
                mismatched++;
                $display("FAIL max_period got %0d want %0d", n, modelLimit(NUM - 1) + 1);
            end
        end
    endtask

    task automatic test_stop();
        int n;
        repeat ($urandom_range(1, 4)) step();
        pulseStop();
        compared++;
        if (dData !== 0 || dRun !== 1'b0 || dTick !== 1'b0 || dLoad !== 1'b1 || dLevel !== mLevel) begin
            mismatched++;
            $display("FAIL stop_state data=%0d run=%0b tick=%0b load=%0b level=%0d want 0/0/0/1/%0d",
                     dData, dRun, dTick, dLoad, dLevel, mLevel);
        end
        repeat ($urandom_range(2, 6)) step();
        compared++;
        if (dData !== 0 || dRun !== 1'b0) begin
            mismatched++;
            $display("FAIL stop_idle data=%0d run=%0b want 0/0", dData, dRun);
        end
        pulseStart();
        compared++;
        if (dLimit !== modelLimit(mLevel) || dLevel !== mLevel) begin
            mismatched++;
            $display("FAIL restart_limit limit=%0d level=%0d want %0d/%0d", dLimit, dLevel, modelLimit(mLevel), mLevel);
        end
        step(); step(); step();
        waitTick(n);
        compared++;
        if (n !== modelLimit(mLevel) + 1) begin
            mismatched++;
            $display("FAIL restart_period got %0d want %0d", n, modelLimit(mLevel) + 1);
        end
    endtask

    task automatic test_saturation();
        forceCmpHigh = 1'b1;
        repeat (300) step();
        compared++;
        if (dData !== {DW{1'b1}} || dTick !== 1'b0) begin
            mismatched++;
            $display("FAIL sat_hold data=%0d tick=%0b want %0d/0", dData, dTick, (1 << DW) - 1);
        end
        forceCmpHigh = 1'b0;
        step();
        compared++;
        if (dTick !== 1'b1 || dData !== 0) begin
            mismatched++;
            $display("FAIL sat_release tick=%0b data=%0d want 1/0", dTick, dData);
        end
    endtask

    task automatic test_pause();
        int n;
        int hold;
        bit found;
        rstn = 1'b0; step(); rstn = 1'b1;
        mLevel = 0;
        pulseStart(); step(); step(); step();
        found = 0;
        for (int i = 0; i < 30 && !found; i++) begin
            if (dData === 5) found = 1;
            else step();
        end
        compared++;
        if (!found) begin
            mismatched++;
            $display("FAIL pause_reach got data=%0d want 5", dData);
        end
        bus.SPEEDCTRL_pause_InLow = 1'b0;
        hold = $urandom_range(15, 25);
        for (int i = 0; i < hold; i++) begin
            step();
            compared++;
            if (dData !== 5 || dTick !== 1'b0) begin
                mismatched++;
                $display("FAIL pause_hold cycle=%0d data=%0d tick=%0b want 5/0", i, dData, dTick);
            end
        end
        bus.SPEEDCTRL_pause_InLow = 1'b1;
        waitTick(n);
        compared++;
        if (n !== 6) begin
            mismatched++;
            $display("FAIL pause_resume got %0d want 6", n);
        end
        // Level-up accepted while paused; pause still applies after reload.
        bus.SPEEDCTRL_pause_InLow = 1'b0;
        step();
        pulseLevelUp();
        mLevel++;
        repeat (3) step();
        repeat (4) step();
        compared++;
        if (dLevel !== mLevel || dRun !== 1'b1 || dData !== 0 || dTick !== 1'b0) begin
            mismatched++;
            $display("FAIL pause_lvl level=%0d run=%0b data=%0d tick=%0b want %0d/1/0/0", dLevel, dRun, dData, dTick, mLevel);
        end
        bus.SPEEDCTRL_pause_InLow = 1'b1;
        waitTick(n);
        compared++;
        if (n !== modelLimit(mLevel) + 1) begin
            mismatched++;
            $display("FAIL pause_lvl_period got %0d want %0d", n, modelLimit(mLevel) + 1);
        end
    endtask

    task automatic test_levelup_with_tick();
        int n;
        bit found;
        found = 0;
        for (int i = 0; i < 30 && !found; i++) begin
            if (dData === modelLimit(mLevel)) found = 1;
            else step();
        end
        pulseLevelUp();
        mLevel++;
        compared++;
        if (!found || dTick !== 1'b1 || dLevel !== mLevel || dRun !== 1'b0 || dData !== 0) begin
            mismatched++;
            $display("FAIL lvl_tick found=%0b tick=%0b level=%0d run=%0b data=%0d want 1/1/%0d/0/0",
                     found, dTick, dLevel, dRun, dData, mLevel);
        end
        step(); step(); step();
        waitTick(n);
        compared++;
        if (n !== modelLimit(mLevel) + 1) begin
            mismatched++;
            $display("FAIL lvl_tick_period got %0d want %0d", n, modelLimit(mLevel) + 1);
        end
    endtask

    task automatic test_reset_during_load();
        pulseLevelUp();
        mLevel++;
        step();
        compared++;
        if (dLoad !== 1'b0) begin
            mismatched++;
            $display("FAIL rstload_inload load=%0b want 0", dLoad);
        end
        rstn = 1'b0; step(); rstn = 1'b1;
        mLevel = 0;
        compared++;
        if (dLoad !== 1'b1 || dLevel !== 0 || dLimit !== modelLimit(0) || dRun !== 1'b0 || dData !== 0) begin
            mismatched++;
            $display("FAIL rstload_state load=%0b level=%0d limit=%0d run=%0b data=%0d want 1/0/%0d/0/0",
                     dLoad, dLevel, dLimit, dRun, dData, modelLimit(0));
        end
        repeat (4) step();
        compared++;
        if (dLoad !== 1'b1 || dRun !== 1'b0) begin
            mismatched++;
            $display("FAIL rstload_idle load=%0b run=%0b want 1/0", dLoad, dRun);
        end
    endtask

    initial begin
        rstn = 1'b0;
        bus.SPEEDCTRL_start_InLow   = 1'b1;
        bus.SPEEDCTRL_stop_InLow    = 1'b1;
        bus.SPEEDCTRL_pause_InLow   = 1'b1;
        bus.SPEEDCTRL_levelUp_InLow = 1'b1;
        test_reset();
        test_start();
        test_level_up();
        test_max_level();
        test_stop();
        test_saturation();
        test_pause();
        test_levelup_with_tick();
        test_reset_during_load();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired compared=%0d", compared);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/speed_level_controller.md
Name: speed_level_controller

Overview:
- Sequences the speed comparator that sets game pace.
- Holds the current speed level and computes the comparator limit from it.
- Drives the comparator's active-low load strobe with a safe setup/strobe/release sequence.
- Runs the data counter the comparator watches, and turns the comparator's match into a one-cycle tick plus counter wrap.

Parameters:
- SPEEDCTRL_DATAWIDTH, 28: width of limit bus and counter; must equal the comparator data width.
- SPEEDCTRL_LEVELWIDTH, 3: width of the level register.
- SPEEDCTRL_NUMLEVELS, 8: number of levels; the maximum level is NUMLEVELS-1.
- SPEEDCTRL_LIMITBASE, 50000000: limit at level 0.
- SPEEDCTRL_LIMITSTEP, 5000000: limit decrement per level.
- SPEEDCTRL_LIMITMIN, 5000000: floor clamp for the limit.

Ports:
- SPEEDCTRL_CLOCK_50  in  1  system clock; all state changes on its rising edge.
- SPEEDCTRL_RESET_InLow  in  1  synchronous reset, active-low.
- SPEEDCTRL_start_InLow  in  1  sampled each cycle; low in IDLE starts the sequence.
- SPEEDCTRL_stop_InLow  in  1  low in any non-IDLE state returns to IDLE.
- SPEEDCTRL_pause_InLow  in  1  level input; low freezes the counter in RUN.
- SPEEDCTRL_levelUp_InLow  in  1  one-cycle low pulse; requests level+1.
- SPEEDCTRL_cmp_InLow  in  1  comparator output; low when counter >= loaded limit.
- SPEEDCTRL_limit_OutBUS  out  DATAWIDTH  limit to the comparator limit input.
- SPEEDCTRL_load_OutLow  out  1  comparator load strobe, active-low.
- SPEEDCTRL_data_OutBUS  out  DATAWIDTH  counter to the comparator data input.
- SPEEDCTRL_tick_Out  out  1  one-cycle high pulse per period.
- SPEEDCTRL_level_OutBUS  out  LEVELWIDTH  current level.
- SPEEDCTRL_running_Out  out  1  high only in RUN.

Behaviour:
- Reset (RESET_InLow low at a rising edge) takes effect at that edge, from any state, including mid-load. After reset:
  - state = IDLE, level = 0, limit = LIMITBASE
  - load = 1, counter = 0, tick = 0, running = 0
- All outputs are registered.
- Limit computation (CALC):
  - limit = LIMITBASE - level*LIMITSTEP, computed at DATAWIDTH+LEVELWIDTH bits.
  - If the product exceeds LIMITBASE, or the result is below LIMITMIN, limit = LIMITMIN.
  - No wrap-around is permitted.
- FSM states: IDLE, CALC, LOAD, SETTLE, RUN.
  - IDLE: load = 1, counter held at 0. start low -> CALC.
  - CALC: registers the new limit; load stays 1 so limit is stable one full cycle before the strobe. -> LOAD.
  - LOAD: load = 0 for exactly one cycle; the comparator captures on this falling edge. Counter cleared to 0. -> SETTLE.
  - SETTLE: load = 1; counter = 0. -> RUN.
  - RUN, each cycle with pause high:
    - cmp_InLow low -> counter <= 0, tick <= 1.
    - otherwise counter <= counter+1, tick <= 0.
    - Tick period is limit+1 cycles.
  - RUN with pause low: counter holds, tick = 0, cmp_InLow is ignored.
- Level-up, accepted only in RUN:
  - level < NUMLEVELS-1: level <= level+1 and state -> CALC.
  - At the maximum level: ignored, no reload, no state change.
  - levelUp in any other state is dropped.
  - Accepted even while paused; the pause is still in effect on re-entering RUN.
- Latency:
  - start low in IDLE at edge N: load low during cycle N+2, running high from N+4.
  - With counter at 0 on entering RUN, the first tick is at RUN entry + limit + 1.
- Simultaneous events (priority: reset > stop > levelUp > tick):
  - levelUp with cmp low in RUN: the tick is still issued that cycle, counter cleared, state -> CALC.
  - stop with anything: -> IDLE, counter 0, load 1, tick 0; level and limit retained.
  - start from IDLE after a stop re-runs CALC with the retained level.
- Counter never exceeds limit in normal operation. If cmp_InLow is stuck high and counter reaches all-ones, it saturates; it does not wrap.

Decomposition:
- Package speed_ctrl_pkg holds:
  - state encoding constants: IDLE=0, CALC=1, LOAD=2, SETTLE=3, RUN=4, in 3 bits;
  - default parameter constants.
- One sub-module, speed_tick_counter, owns:
  - inputs clear, enable, cmp;
  - outputs count and tick;
  - the saturation rule.
- The FSM, level register and limit arithmetic stay in the top module.

Test Plan:
All scenarios use DATAWIDTH=8, BASE=10, STEP=3, MIN=2, NUMLEVELS=4, with a behavioural comparator model.
- Reset then start pulse -> load low exactly one cycle at N+2 with limit=10; running at N+4; ticks every 11 cycles.
- levelUp pulses x3 in RUN -> limits 7, 4, then 2 (clamped from 1); periods 8, 5, 3; each preceded by a one-cycle load-low with limit stable the prior cycle.
- A 4th levelUp at level 3 -> no load pulse; level stays 3; tick period stays 3.
- pause low for 20 cycles mid-count at counter=5 -> counter holds 5, no ticks; resume -> next tick 6 cycles later (counter 5→10, then tick).
- levelUp in the same cycle cmp goes low -> tick high that cycle, level increments, CALC next.
- reset low during LOAD -> next edge load=1, level=0, limit=10, IDLE; stop during RUN -> counter 0, running 0, level retained on restart.
